capture_bank: RTL and testbench

Parametrised multi-channel capture register bank. It is the clocked, multi-channel successor to the single-bit enable-gated storage element. Each channel holds a WIDTH-bit value that loads on its own enable. A freeze request stops all loading and runs a readout sequencer that presents every channel, in order, over a valid/ready handshake. It sits between asynchronous-rate producers and a single status/debug reader.

---
 rtl/capture_bank.sv | 119 +++++++++++
 tb/tb_capture_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_bank.sv
// rtl/capture_bank.sv - multi-channel capture bank with freeze-triggered readout sequencer
// Optional sticky change flags are built only when CAPTURE_CHANGED_EN is defined.
module capture_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      freeze,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       changed,
  output logic                      scan_valid,
  input  logic                      scan_ready,
  output logic [CW-1:0]             scan_ch,
  output logic [WIDTH-1:0]          scan_data
);

  typedef enum logic [1:0] {TRACK, SCAN, RELEASE} state_e;

  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  state_e                      state_q, state_d;
  logic [CW-1:0]               ch_q, ch_d;
  logic                        valid_q, valid_d;
  logic [CHANNELS*WIDTH-1:0]   data_q, data_d;
  logic                        load_open;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TRACK;
      ch_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    load_open = 1'b0;
    case (state_q)
      TRACK: begin
        load_open = 1'b1;
        if (freeze) begin
          state_d = SCAN;
          ch_d    = '0;
        end
      end
      SCAN: begin
        // freeze is deliberately not looked at here: a started scan always completes
        if (scan_ready) begin
          if (ch_q == LAST_CH) begin
            state_d = RELEASE;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!freeze) state_d = TRACK;
      end
      default: state_d = TRACK;
    endcase
    valid_d = (state_d == SCAN);

    data_d = data_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load_open && en[i]) data_d[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    scan_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == CW'(i)) scan_data = data_q[i*WIDTH +: WIDTH];
    end
  end

  assign q          = data_q;
  assign scan_valid = valid_q;
  assign scan_ch    = ch_q;

`ifdef CAPTURE_CHANGED_EN
  logic [CHANNELS-1:0] chg_q, chg_d;
  logic                hs;

  assign hs = valid_q & scan_ready;

  // Set and clear never coincide: loads are only open outside SCAN.
  always_comb begin
    chg_d = chg_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load_open && en[i] && (d[i*WIDTH +: WIDTH] != data_q[i*WIDTH +: WIDTH]))
        chg_d[i] = 1'b1;
      if (hs && (ch_q == CW'(i)))
        chg_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chg_q <= '0;
    else      chg_q <= chg_d;
  end

  assign changed = chg_q;
`else
  assign changed = '0;
`endif

endmodule

// File: tb/tb_capture_bank.sv
// tb/tb_capture_bank.sv - randomized model-checked bench for capture_bank
// Honours CAPTURE_CHANGED_EN the same way as the design.
module tb_capture_bank;
  localparam int W  = 8;
  localparam int C  = 4;
  localparam int CW = $clog2(C);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [C-1:0]   en = '0;
  logic [C*W-1:0] d = '0;
  logic           freeze = 1'b0;
  logic           scan_ready = 1'b0;
  logic [C*W-1:0] q;
  logic [C-1:0]   changed;
  logic           scan_valid;
  logic [CW-1:0]  scan_ch;
  logic [W-1:0]   scan_data;

  int tests = 0;
  int errors = 0;

  capture_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .freeze(freeze), .q(q),
    .changed(changed), .scan_valid(scan_valid), .scan_ready(scan_ready),
    .scan_ch(scan_ch), .scan_data(scan_data)
  );

  always #5 clk = ~clk;

  // Reference: stored values, whether a readout is in progress and at which word,
  // and whether we are waiting for freeze to drop after a finished readout.
  logic [W-1:0] m_val[C];
  logic [C-1:0] m_chg;
  bit           m_scanning;
  bit           m_wait_low;
  int           m_word;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < C; i++) m_val[i] = '0;
      m_chg = '0; m_scanning = 0; m_wait_low = 0; m_word = 0;
    end else if (m_scanning) begin
      if (scan_ready) begin
        m_chg[m_word] = 1'b0;
        m_word = m_word + 1;
        if (m_word == C) begin
          m_scanning = 0; m_wait_low = 1; m_word = 0;
        end
      end
    end else if (m_wait_low) begin
      if (!freeze) m_wait_low = 0;
    end else begin
      for (int i = 0; i < C; i++) begin
        if (en[i]) begin
          if (d[i*W +: W] != m_val[i]) m_chg[i] = 1'b1;
          m_val[i] = d[i*W +: W];
        end
      end
      if (freeze) begin
        m_scanning = 1; m_word = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [C*W-1:0] eq;
    logic [C-1:0]   ec;
    for (int i = 0; i < C; i++) eq[i*W +: W] = m_val[i];
`ifdef CAPTURE_CHANGED_EN
    ec = m_chg;
`else
    ec = '0;
`endif
    chk("cmp_q", 64'(q), 64'(eq));
    chk("cmp_changed", 64'(changed), 64'(ec));
    chk("cmp_valid", 64'(scan_valid), 64'(m_scanning));
    if (m_scanning) begin
      chk("cmp_ch", 64'(scan_ch), 64'(m_word));
      chk("cmp_data", 64'(scan_data), 64'(m_val[m_word]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  logic [W-1:0] exp_words[C];

  initial begin
    exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33; exp_words[3] = 8'h44;

    run(2);
    rst = 1'b1;
    cyc();
    chk("reset_q", 64'(q), 64'h0);
    chk("reset_valid", 64'(scan_valid), 64'h0);
    chk("reset_ch", 64'(scan_ch), 64'h0);
    chk("reset_changed", 64'(changed), 64'h0);

    en = 4'b0101; d = 32'h00330011;
    cyc(); en = '0;
    chk("load_0101", 64'(q), 64'h00330011);

    en = 4'b1111; d = 32'h44332211;
    cyc(); en = '0;
    scan_ready = 1'b1; freeze = 1'b1;
    cyc(); freeze = 1'b0;
    for (int k = 0; k < C; k++) begin
      chk("scan_valid", 64'(scan_valid), 64'h1);
      chk("scan_ch", 64'(scan_ch), 64'(k));
      chk("scan_word", 64'(scan_data), 64'(exp_words[k]));
      cyc();
    end
    chk("scan_done_valid", 64'(scan_valid), 64'h0);
    cyc();

    freeze = 1'b1;
    cyc(); freeze = 1'b0;
    cyc();
    scan_ready = 1'b0; en = 4'b1111; d = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_ch", 64'(scan_ch), 64'h1);
      chk("bp_data", 64'(scan_data), 64'h22);
    end
    en = '0; scan_ready = 1'b1;
    run(4);
    chk("bp_q_kept", 64'(q), 64'h44332211);

    freeze = 1'b1; en = 4'b0001; d = 32'h0000005A;
    cyc(); en = '0;
    chk("simul_ch", 64'(scan_ch), 64'h0);
    chk("simul_data", 64'(scan_data), 64'h5A);
    run(4);
    en = 4'b0001; d = 32'h00000077;
    run(3);
    chk("release_hold_valid", 64'(scan_valid), 64'h0);
    chk("release_blocks_load", 64'(q), 64'h4433225A);
    freeze = 1'b0; en = '0;
    cyc();
    en = 4'b0001; d = 32'h00000011;
    cyc(); en = '0;
    chk("post_release_load", 64'(q), 64'h44332211);

    freeze = 1'b1;
    cyc(); freeze = 1'b0;
    run(2);
    rst = 1'b0;
    #1;
    chk("midrst_q", 64'(q), 64'h0);
    chk("midrst_valid", 64'(scan_valid), 64'h0);
    chk("midrst_ch", 64'(scan_ch), 64'h0);
    cyc(); rst = 1'b1;
    cyc();
    en = 4'b0001; d = 32'h000000AB;
    cyc(); en = '0;
    chk("after_rst_load", 64'(q), 64'h000000AB);
    freeze = 1'b1;
    cyc(); freeze = 1'b0;
    chk("rescan_ch", 64'(scan_ch), 64'h0);
    chk("rescan_data", 64'(scan_data), 64'hAB);
    run(5);

    en = 4'b1000; d = 32'h44000000;
    cyc();
    d = 32'h45000000;
    cyc();
`ifdef CAPTURE_CHANGED_EN
    chk("chg3_set", 64'(changed[3]), 64'h1);
`else
    chk("chg_off", 64'(changed), 64'h0);
`endif
    cyc(); en = '0;
`ifdef CAPTURE_CHANGED_EN
    chk("chg3_same", 64'(changed[3]), 64'h1);
`else
    chk("chg_off_same", 64'(changed), 64'h0);
`endif
    freeze = 1'b1;
    cyc(); freeze = 1'b0;
    run(4);
    chk("chg3_cleared", 64'(changed[3]), 64'h0);
    cyc();

    for (int n = 0; n < 3000; n++) begin
      en = C'($urandom);
      d = {$urandom};
      scan_ready = ($urandom % 4) != 0;
      if ($urandom % 8 == 0) freeze = ~freeze;
      if ($urandom % 600 == 0) begin
        rst = 1'b0;
        cyc();
        rst = 1'b1;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
